// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard controller for a five-stage pipeline. Bubble and flush outputs are
// derived combinationally from the hazard inputs and the current state. The
// state, the memory-wait counter and the stall-cycle counter are registered.
//
// A memory access that outstays TIMEOUT wait cycles latches a sticky error.
// That error freezes the whole pipe until reset.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reg_src1_D, reg_src2_D   source registers of the instruction in ID
//   reg_dest_E, mem_read_E   destination register / load flag of EX instruction
//   br_taken_E               taken branch or JALR resolved in EX
//   jal_D                    JAL decoded in ID
//   mem_req_M, mem_ready_M   data-memory request / completion in MEM
//   bubbleF..bubbleW         hold the corresponding stage register
//   flushD..flushW           load a NOP into the corresponding stage register
//   mem_timeout              sticky memory-timeout error
//   stall_cycles             free-running count of cycles with any bubble
//
// state    | meaning
// RUN      | normal operation, no outstanding memory wait
// MEM_WAIT | data memory has not completed; wait counter running
// ERROR    | memory wait exceeded TIMEOUT; pipe frozen until rst
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  reg_src1_D,
    input  logic [4:0]  reg_src2_D,
    input  logic [4:0]  reg_dest_E,
    input  logic        mem_read_E,
    input  logic        br_taken_E,
    input  logic        jal_D,
    input  logic        mem_req_M,
    input  logic        mem_ready_M,
    output logic        bubbleF,
    output logic        bubbleD,
    output logic        bubbleE,
    output logic        bubbleM,
    output logic        bubbleW,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic load_use;
    logic any_bubble;

    assign mem_stall = mem_req_M & ~mem_ready_M;
    // x0 is hard-wired to zero, so a load targeting it can never create a hazard.
    assign load_use  = mem_read_E & (reg_dest_E != 5'd0) &
                       ((reg_dest_E == reg_src1_D) | (reg_dest_E == reg_src2_D));

    // Next-state and wait counter
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end else begin
                    wait_cnt_d = 16'd0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_M) begin
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                end else if (mem_stall) begin
                    // The counter already holds the number of wait cycles spent,
                    // including this one. If that has reached the limit, give up.
                    if (wait_cnt_q >= TIMEOUT_C) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    // Bubble/flush outputs, priority ERROR > mem_stall > branch > load-use > JAL
    always_comb begin
        bubbleF = 1'b0;
        bubbleD = 1'b0;
        bubbleE = 1'b0;
        bubbleM = 1'b0;
        bubbleW = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        flushW  = 1'b0;
        if (rst) begin
            // Keep the pipe quiet while reset is held.
        end else if (state_q == ERROR) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            bubbleM = 1'b1;
            bubbleW = 1'b1;
        end else if (mem_stall) begin
            // Hold IF..MEM. WB drains, so inject a NOP there instead of re-retiring.
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            bubbleM = 1'b1;
            flushW  = 1'b1;
        end else if (br_taken_E) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_use) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end else if (jal_D) begin
            flushD = 1'b1;
        end
    end

    assign any_bubble  = bubbleF | bubbleD | bubbleE | bubbleM | bubbleW;
    assign stall_cnt_d = stall_cnt_q + {31'd0, any_bubble};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 16'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_timeout  = (state_q == ERROR);
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg_src1_D, reg_src2_D, reg_dest_E;
    logic        mem_read_E, br_taken_E, jal_D, mem_req_M, mem_ready_M;
    logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic        flushD, flushE, flushM, flushW;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_sc = 32'd0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .reg_src1_D(reg_src1_D), .reg_src2_D(reg_src2_D),
        .reg_dest_E(reg_dest_E), .mem_read_E(mem_read_E),
        .br_taken_E(br_taken_E), .jal_D(jal_D),
        .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
        .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE),
        .bubbleM(bubbleM), .bubbleW(bubbleW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    // bubble = {F,D,E,M,W}, flush = {D,E,M,W}
    typedef struct {
        string      name;
        logic [4:0] src1, src2, dest;
        logic       mr, br, jal, req, rdy;
        logic [4:0] bub;
        logic [3:0] fl;
    } vec_t;

    vec_t vecs[10];

    task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic mr, input logic br, input logic jal,
                         input logic req, input logic rdy);
        reg_src1_D  = s1;
        reg_src2_D  = s2;
        reg_dest_E  = d;
        mem_read_E  = mr;
        br_taken_E  = br;
        jal_D       = jal;
        mem_req_M   = req;
        mem_ready_M = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_out(input string name, input logic [4:0] eb, input logic [3:0] ef,
                           input logic eto);
        logic [4:0] ab;
        logic [3:0] af;
        ab = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW};
        af = {flushD, flushE, flushM, flushW};
        total++;
        if (ab !== eb) begin
            bad++;
            $display("FAIL %s bubbles: got %b want %b", name, ab, eb);
        end
        total++;
        if (af !== ef) begin
            bad++;
            $display("FAIL %s flushes: got %b want %b", name, af, ef);
        end
        total++;
        if (mem_timeout !== eto) begin
            bad++;
            $display("FAIL %s mem_timeout: got %b want %b", name, mem_timeout, eto);
        end
    endtask

    task automatic chk_sc(input string name);
        total++;
        if (stall_cycles !== exp_sc) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles, exp_sc);
        end
    endtask

    // Advance one clock; the model counts the cycle if a bubble was expected.
    task automatic tick(input string name, input logic counted);
        @(posedge clk);
        if (counted) exp_sc = exp_sc + 32'd1;
        @(negedge clk);
        chk_sc(name);
    endtask

    // From RUN: one RUN stall cycle plus four MEM_WAIT cycles, then ERROR.
    task automatic timeout_seq(input string tag);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1 chk_out($sformatf("%s_wait%0d", tag, c), 5'b11110, 4'b0001, 1'b0);
            tick($sformatf("%s_wait%0d", tag, c), 1'b1);
        end
        #1 chk_out({tag, "_err"}, 5'b11111, 4'b0000, 1'b1);
        // Neither memory completion nor hazards clear the error.
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #1 chk_out({tag, "_err_sticky"}, 5'b11111, 4'b0000, 1'b1);
        tick({tag, "_err_sticky"}, 1'b1);
        #1 chk_out({tag, "_err_hold"}, 5'b11111, 4'b0000, 1'b1);
    endtask

    initial begin
        vecs[0] = '{"idle",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000};
        vecs[1] = '{"loaduse_s2",  5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 4'b0100};
        vecs[2] = '{"br_over_lu",  5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b1100};
        vecs[3] = '{"x0_no_lu",    5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000};
        vecs[4] = '{"jal_only",    5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 4'b1000};
        vecs[5] = '{"lu_over_jal", 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000, 4'b0100};
        vecs[6] = '{"br_over_jal", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 4'b1100};
        vecs[7] = '{"no_load",     5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000};
        vecs[8] = '{"no_match",    5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000};
        vecs[9] = '{"mem_ready",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 4'b0000};

        // Reset state, outputs quiet while reset held even with hazards present
        rst = 1'b1;
        drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        chk_out("reset_hold", 5'b00000, 4'b0000, 1'b0);
        chk_sc("reset_hold");
        @(negedge clk);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1 chk_out("post_reset", 5'b00000, 4'b0000, 1'b0);

        // Table vectors, all from RUN
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].src1, vecs[i].src2, vecs[i].dest, vecs[i].mr,
                  vecs[i].br, vecs[i].jal, vecs[i].req, vecs[i].rdy);
            #1 chk_out(vecs[i].name, vecs[i].bub, vecs[i].fl, 1'b0);
            tick(vecs[i].name, |vecs[i].bub);
        end

        // Three-cycle memory stall, then completion. The stall overrides branch/load-use.
        for (int c = 0; c < 3; c++) begin
            if (c == 1) drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            else        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1 chk_out($sformatf("memstall%0d", c), 5'b11110, 4'b0001, 1'b0);
            tick($sformatf("memstall%0d", c), 1'b1);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 chk_out("mem_done", 5'b00000, 4'b0000, 1'b0);
        tick("mem_done", 1'b0);
        // The pipe is back in RUN, so a JAL gives a plain flushD.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk_out("run_after_mem", 5'b00000, 4'b1000, 1'b0);
        tick("run_after_mem", 1'b0);

        timeout_seq("to1");

        // Asynchronous reset out of ERROR, between clock edges
        #2 rst = 1'b1;
        exp_sc = 32'd0;
        #1 chk_out("rst_from_err", 5'b00000, 4'b0000, 1'b0);
        chk_sc("rst_from_err");
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1 chk_out("err_released", 5'b00000, 4'b0000, 1'b0);
        tick("err_released", 1'b0);

        // Asynchronous reset in the middle of MEM_WAIT, with the stall still requested
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk_out("mw_a", 5'b11110, 4'b0001, 1'b0);
        tick("mw_a", 1'b1);
        #1 chk_out("mw_b", 5'b11110, 4'b0001, 1'b0);
        tick("mw_b", 1'b1);
        #2 rst = 1'b1;
        exp_sc = 32'd0;
        #1 chk_out("rst_mid_wait", 5'b00000, 4'b0000, 1'b0);
        chk_sc("rst_mid_wait");
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #1 chk_out("run_after_rst", 5'b00000, 4'b1000, 1'b0);
        tick("run_after_rst", 1'b0);

        // The wait counter restarted from zero, so the timeout again takes the full count.
        timeout_seq("to2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max consecutive memory-wait cycles before error (1..65535).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have ports: reg_src1_D, reg_src2_D  input  5  source registers of the instruction in ID.
REQ-005 SHALL have ports: reg_dest_E  input  5, mem_read_E  input  1  destination register and load flag of the instruction in EX.
REQ-006 SHALL have ports: br_taken_E  input  1  taken branch/JALR resolved in EX; jal_D  input  1  JAL decoded in ID.
REQ-007 SHALL have ports: mem_req_M  input  1, mem_ready_M  input  1  data-memory request and completion in MEM.
REQ-008 SHALL have ports: bubbleF, bubbleD, bubbleE, bubbleM, bubbleW  output  1  hold the stage register.
REQ-009 SHALL have ports: flushD, flushE, flushM, flushW  output  1  load a NOP (dest 0) into the stage register.
REQ-010 SHALL have ports: mem_timeout  output  1  sticky error; stall_cycles  output  32  count of stalled cycles.

Function
REQ-011 SHALL implement FSM states RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-012 mem_stall = mem_req_M & ~mem_ready_M; SHALL be combinational from inputs in RUN and MEM_WAIT.
REQ-013 RUN -> MEM_WAIT when mem_stall=1; MEM_WAIT -> RUN when mem_ready_M=1; MEM_WAIT -> ERROR when wait counter reaches TIMEOUT with mem_stall still 1; ERROR exits only on rst.
REQ-014 Wait counter (16 bit) SHALL clear on entry to MEM_WAIT / in RUN and increment each MEM_WAIT cycle with mem_stall=1; counter value 1 on the first MEM_WAIT cycle.
REQ-015 When mem_stall=1 (any non-ERROR state): bubbleF=bubbleD=bubbleE=bubbleM=1, flushW=1, bubbleW=0, all other flushes 0; overrides every other rule.
REQ-016 In ERROR: all five bubbles 1, all flushes 0, mem_timeout=1.
REQ-017 load_use = mem_read_E & (reg_dest_E!=0) & (reg_dest_E==reg_src1_D | reg_dest_E==reg_src2_D).
REQ-018 br_taken_E=1 (no mem_stall): flushD=1, flushE=1, no bubbles; SHALL win over load_use and jal_D.
REQ-019 load_use=1 (no mem_stall, no br_taken_E): bubbleF=1, bubbleD=1, flushE=1; jal_D ignored this cycle.
REQ-020 jal_D=1 alone: flushD=1 only.
REQ-021 No condition active: all bubbles and flushes 0; flushM never asserted except reserved 0.
REQ-022 Priority SHALL be ERROR > mem_stall > br_taken_E > load_use > jal_D.
REQ-023 stall_cycles SHALL increment by 1 each cycle any bubble output is 1, wrapping 0xFFFFFFFF -> 0.
REQ-024 Reg x0 as reg_dest_E SHALL never trigger load_use.
REQ-025 All bubble/flush outputs SHALL be combinational (zero latency) from inputs and current state; counters and state registered.

Reset
REQ-026 rst=1 SHALL immediately force state RUN, wait counter 0, stall_cycles 0, mem_timeout 0, independent of clk.
REQ-027 During rst=1 all bubble and flush outputs SHALL be 0.
REQ-028 rst asserted in MEM_WAIT or ERROR SHALL return to RUN on the first clk edge after release, with no residual stall.

Verification
REQ-029 reg_dest_E=5, mem_read_E=1, reg_src2_D=5 -> bubbleF=bubbleD=flushE=1, stall_cycles +1.
REQ-030 Same load_use plus br_taken_E=1 -> flushD=flushE=1, bubbleF=bubbleD=0.
REQ-031 mem_req_M=1, mem_ready_M=0 for 3 cycles then 1 -> 3 cycles bubbleF..M=1, flushW=1; 4th cycle all 0, state RUN, stall_cycles=3.
REQ-032 TIMEOUT=4, mem_ready_M held 0 -> ERROR after 4 wait cycles, mem_timeout=1, all bubbles 1 until rst.
REQ-033 reg_dest_E=0, mem_read_E=1, reg_src1_D=0 -> no stall; jal_D=1 -> flushD=1 only.
REQ-034 rst pulsed mid-MEM_WAIT (async, between edges) -> outputs 0 immediately, stall_cycles=0, mem_timeout=0.
